// File: rtl/ae350_aopd_pkg.sv
// Shared definitions for the always-on power-domain (AOPD) reset-request path.
//   rq_state_e : reset-request sequencer states
//   RSN_*      : bit positions inside the sticky rst_reason vector
package ae350_aopd_pkg;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_HOLD,
    RQ_WAIT,
    RQ_COOL
  } rq_state_e;

  localparam int RSN_EXT = 0;
  localparam int RSN_WDT = 1;
  localparam int RSN_SW  = 2;
  localparam int RSN_W   = 3;

endpackage : ae350_aopd_pkg

// File: rtl/ae350_aopd_sync2.sv
// Two-flop synchroniser for one asynchronous level into the clk_32k domain.
// Both flops reset to RST_VAL, which is the inactive level of the input, so no
// spurious request is seen while the always-on domain leaves reset.
// Ports:
//   clk_32k          in  always-on clock
//   por_dbg_mix_rstn in  asynchronous active-low reset
//   d                in  asynchronous level
//   q                out synchronised level
module ae350_aopd_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_32k,
  input  logic por_dbg_mix_rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_32k or negedge por_dbg_mix_rstn) begin
    if (!por_dbg_mix_rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : ae350_aopd_sync2

// File: rtl/ae350_aopd_rstreq_seq.sv
// Always-on reset-request sequencer (initiator side of the AOPD reset path).
// Merges external-pin, watchdog and software reset requests, stretches the core
// reset for HOLD_CYC cycles, waits up to TMO_CYC cycles for core_rdy, then blanks
// new requests for COOL_CYC cycles. The request sources and any timeout are kept
// as sticky flags for software until a reason_clr rising edge.
// Optional feature macro: AOPD_RSTREQ_DEBOUNCE_EN (ext pin must be low for
// DBNC_CYC synced cycles before it counts as a request).
// Ports:
//   clk_32k          in  32.768 kHz always-on clock
//   por_dbg_mix_rstn in  asynchronous active-low reset
//   ext_rstn_pad     in  external reset pin, async, active-low
//   wdt_rst_req      in  watchdog request, async level, active-high
//   sw_rst_req       in  software request, pclk-domain level, active-high
//   core_rdy         in  core domain out of reset, async level
//   reason_clr       in  async level; synced rising edge clears the sticky flags
//   core_rstn_out    out registered active-low reset to the core domain
//   rst_busy         out high whenever the sequencer is not idle
//   rst_reason       out sticky {sw, wdt, ext} request record
//   timeout_flag     out sticky; set when waiting for core_rdy timed out
module ae350_aopd_rstreq_seq
  import ae350_aopd_pkg::*;
#(
  parameter int HOLD_CYC = 32,
  parameter int TMO_CYC  = 1024,
  parameter int COOL_CYC = 16,
`ifdef AOPD_RSTREQ_DEBOUNCE_EN
  parameter int DBNC_CYC = 8,
`endif
  parameter int CNT_W    = 11
) (
  input  logic             clk_32k,
  input  logic             por_dbg_mix_rstn,
  input  logic             ext_rstn_pad,
  input  logic             wdt_rst_req,
  input  logic             sw_rst_req,
  input  logic             core_rdy,
  input  logic             reason_clr,
  output logic             core_rstn_out,
  output logic             rst_busy,
  output logic [RSN_W-1:0] rst_reason,
  output logic             timeout_flag
);

  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_END = CNT_W'(COOL_CYC - 1);

  logic ext_s, wdt_s, sw_s, rdy_s, clr_s, clr_d;
  logic ext_lo, req, clr_edge;
  logic [RSN_W-1:0] req_vec;

  rq_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_term;
  logic             boot, tmo_set;

  // ---------------------------------------------------------------- sync
  ae350_aopd_sync2 #(.RST_VAL(1'b1)) u_sync_ext (
    .clk_32k(clk_32k), .por_dbg_mix_rstn(por_dbg_mix_rstn), .d(ext_rstn_pad), .q(ext_s));
  ae350_aopd_sync2 #(.RST_VAL(1'b0)) u_sync_wdt (
    .clk_32k(clk_32k), .por_dbg_mix_rstn(por_dbg_mix_rstn), .d(wdt_rst_req), .q(wdt_s));
  ae350_aopd_sync2 #(.RST_VAL(1'b0)) u_sync_sw (
    .clk_32k(clk_32k), .por_dbg_mix_rstn(por_dbg_mix_rstn), .d(sw_rst_req), .q(sw_s));
  ae350_aopd_sync2 #(.RST_VAL(1'b0)) u_sync_rdy (
    .clk_32k(clk_32k), .por_dbg_mix_rstn(por_dbg_mix_rstn), .d(core_rdy), .q(rdy_s));
  ae350_aopd_sync2 #(.RST_VAL(1'b0)) u_sync_clr (
    .clk_32k(clk_32k), .por_dbg_mix_rstn(por_dbg_mix_rstn), .d(reason_clr), .q(clr_s));

  // Third flop on the clear path: a level held high clears only once.
  always_ff @(posedge clk_32k or negedge por_dbg_mix_rstn) begin
    if (!por_dbg_mix_rstn) clr_d <= 1'b0;
    else                   clr_d <= clr_s;
  end

  assign clr_edge = clr_s & ~clr_d;

  // ------------------------------------------------------- ext pin filter
`ifdef AOPD_RSTREQ_DEBOUNCE_EN
  localparam int              DB_W   = $clog2(DBNC_CYC + 1);
  localparam logic [DB_W-1:0] DB_END = DB_W'(DBNC_CYC);

  logic [DB_W-1:0] db_cnt;

  // Counts consecutive low samples before this one; the current sample must
  // also be low, so a low run of DBNC_CYC+1 samples is needed and any high
  // sample drops the request at once.
  always_ff @(posedge clk_32k or negedge por_dbg_mix_rstn) begin
    if (!por_dbg_mix_rstn)  db_cnt <= '0;
    else if (ext_s)         db_cnt <= '0;
    else if (db_cnt != DB_END) db_cnt <= db_cnt + 1'b1;
  end

  assign ext_lo = ~ext_s & (db_cnt == DB_END);
`else
  assign ext_lo = ~ext_s;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    req_vec          = '0;
    req_vec[RSN_EXT] = ext_lo;
    req_vec[RSN_WDT] = wdt_s;
    req_vec[RSN_SW]  = sw_s;
  end

  assign req = |req_vec;

  // ------------------------------------------------------------------ FSM
  // The counter saturates at the terminal value of the current state; in
  // practice every terminal count also triggers a state change that clears it.
  always_comb begin
    cnt_term = '0;
    case (state)
      RQ_HOLD: cnt_term = HOLD_END;
      RQ_WAIT: cnt_term = TMO_END;
      RQ_COOL: cnt_term = COOL_END;
      default: cnt_term = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == cnt_term) ? cnt : cnt + 1'b1;
    tmo_set   = 1'b0;
    case (state)
      RQ_IDLE: begin
        cnt_nxt = cnt;
        if (req) begin
          state_nxt = RQ_HOLD;
          cnt_nxt   = '0;
        end
      end
      RQ_HOLD: begin
        if (req) begin
          cnt_nxt = '0;              // stretch while any request persists
        end else if (cnt == HOLD_END) begin
          state_nxt = RQ_WAIT;
          cnt_nxt   = '0;
        end
      end
      RQ_WAIT: begin
        if (req) begin
          state_nxt = RQ_HOLD;       // re-assert the core reset
          cnt_nxt   = '0;
        end else if (rdy_s) begin
          state_nxt = RQ_COOL;
          cnt_nxt   = '0;
        end else if (cnt == TMO_END) begin
          state_nxt = RQ_COOL;
          cnt_nxt   = '0;
          tmo_set   = 1'b1;
        end
      end
      RQ_COOL: begin
        // boot: the post-reset COOL lasts a single cycle.
        if (boot || cnt == COOL_END) begin
          state_nxt = RQ_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RQ_COOL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_32k or negedge por_dbg_mix_rstn) begin
    if (!por_dbg_mix_rstn) begin
      state         <= RQ_COOL;
      cnt           <= '0;
      boot          <= 1'b1;
      core_rstn_out <= 1'b0;
      rst_reason    <= '0;
      timeout_flag  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      boot          <= 1'b0;
      // Registered from the next state so the core reset has no comb glitches.
      core_rstn_out <= (state_nxt != RQ_HOLD);
      // A set in the same cycle as the clear edge wins for that bit.
      rst_reason    <= (clr_edge ? '0 : rst_reason) | req_vec;
      timeout_flag  <= (clr_edge ? 1'b0 : timeout_flag) | tmo_set;
    end
  end

  assign rst_busy = (state != RQ_IDLE);

endmodule : ae350_aopd_rstreq_seq

// File: tb/tb_ae350_aopd_rstreq_seq.sv
// Self-checking bench for ae350_aopd_rstreq_seq. Inputs change on the falling
// edge; the reference model advances once per rising edge (evaluated at the
// following falling edge) and all outputs are compared every cycle.
module tb_ae350_aopd_rstreq_seq;

  localparam int HOLD = 32;
  localparam int TMO  = 1024;
  localparam int COOL = 16;
  localparam int DBNC = 8;
  localparam int HN   = 12;

  logic       clk_32k = 1'b0;
  logic       por_dbg_mix_rstn = 1'b0;
  logic       ext_rstn_pad = 1'b1;
  logic       wdt_rst_req = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       core_rdy = 1'b0;
  logic       reason_clr = 1'b0;
  logic       core_rstn_out;
  logic       rst_busy;
  logic [2:0] rst_reason;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;

  ae350_aopd_rstreq_seq dut (
    .clk_32k         (clk_32k),
    .por_dbg_mix_rstn(por_dbg_mix_rstn),
    .ext_rstn_pad    (ext_rstn_pad),
    .wdt_rst_req     (wdt_rst_req),
    .sw_rst_req      (sw_rst_req),
    .core_rdy        (core_rdy),
    .reason_clr      (reason_clr),
    .core_rstn_out   (core_rstn_out),
    .rst_busy        (rst_busy),
    .rst_reason      (rst_reason),
    .timeout_flag    (timeout_flag)
  );

  always #10 clk_32k = ~clk_32k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  // Phase plus "cycles left" timer; inputs reach the model two edges late
  // through per-input history arrays (index 0 = most recent edge).
  typedef enum int {M_IDLE, M_HOLD, M_WAIT, M_COOL} mphase_e;

  mphase_e    ph;
  int         left;
  bit         m_rstn, m_tmo;
  bit [2:0]   m_reason;
  bit         h_pad[HN], h_wdt[HN], h_sw[HN], h_rdy[HN], h_clr[HN];

  task automatic model_reset();
    ph = M_COOL; left = 1;
    m_rstn = 1'b0; m_tmo = 1'b0; m_reason = '0;
    for (int k = 0; k < HN; k++) begin
      h_pad[k] = 1'b1; h_wdt[k] = 1'b0; h_sw[k] = 1'b0; h_rdy[k] = 1'b0; h_clr[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit ext, wdt, sw, rdy, clr_edge, req, tmo_now;
    for (int k = HN - 1; k > 0; k--) begin
      h_pad[k] = h_pad[k-1]; h_wdt[k] = h_wdt[k-1]; h_sw[k] = h_sw[k-1];
      h_rdy[k] = h_rdy[k-1]; h_clr[k] = h_clr[k-1];
    end
    h_pad[0] = ext_rstn_pad; h_wdt[0] = wdt_rst_req; h_sw[0] = sw_rst_req;
    h_rdy[0] = core_rdy;     h_clr[0] = reason_clr;

`ifdef AOPD_RSTREQ_DEBOUNCE_EN
    // Request once the synced pin has been low for DBNC earlier samples plus
    // the current one (gives DBNC+3 cycles pad-to-reset latency).
    ext = 1'b1;
    for (int k = 2; k <= 2 + DBNC; k++) if (h_pad[k]) ext = 1'b0;
`else
    ext = !h_pad[2];
`endif
    wdt      = h_wdt[2];
    sw       = h_sw[2];
    rdy      = h_rdy[2];
    clr_edge = h_clr[2] && !h_clr[3];
    req      = ext || wdt || sw;
    tmo_now  = 1'b0;

    case (ph)
      M_IDLE: if (req) begin ph = M_HOLD; left = HOLD; end
      M_HOLD: begin
        if (req) left = HOLD;
        else begin
          left--;
          if (left == 0) begin ph = M_WAIT; left = TMO; end
        end
      end
      M_WAIT: begin
        if (req)      begin ph = M_HOLD; left = HOLD; end
        else if (rdy) begin ph = M_COOL; left = COOL; end
        else begin
          left--;
          if (left == 0) begin tmo_now = 1'b1; ph = M_COOL; left = COOL; end
        end
      end
      default: begin
        left--;
        if (left == 0) ph = M_IDLE;
      end
    endcase

    if (clr_edge) begin m_reason = '0; m_tmo = 1'b0; end
    m_reason = m_reason | {sw, wdt, ext};
    if (tmo_now) m_tmo = 1'b1;
    m_rstn = (ph != M_HOLD);
  endtask

  // One clock: advance model for the rising edge just taken, compare outputs.
  task automatic tick();
    @(negedge clk_32k);
    if (por_dbg_mix_rstn) model_step();
    check("core_rstn_out", 32'(core_rstn_out), 32'(m_rstn));
    check("rst_busy",      32'(rst_busy),      32'(ph != M_IDLE));
    check("rst_reason",    32'(rst_reason),    32'(m_reason));
    check("timeout_flag",  32'(timeout_flag),  32'(m_tmo));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_flags();
    reason_clr = 1'b1; tick();
    reason_clr = 1'b0; ticks(4);
  endtask

  // ------------------------------------------------------------- stimulus
  int pad_t, wdt_t, sw_t;

  initial begin
    model_reset();
    ticks(2);
    check("reset_busy", 32'(rst_busy), 32'd1);
    check("reset_rstn", 32'(core_rstn_out), 32'd0);
    por_dbg_mix_rstn = 1'b1;
    tick();
    check("boot_idle", 32'(rst_busy), 32'd0);
    check("boot_rstn", 32'(core_rstn_out), 32'd1);

    // 1: ext pin low for 5 clk, core_rdy 10 clk after release.
    ext_rstn_pad = 1'b0; ticks(5);
    ext_rstn_pad = 1'b1; ticks(2 + 4 + HOLD);
    check("t1_released", 32'(core_rstn_out), 32'd1);
    ticks(10);
    core_rdy = 1'b1; ticks(3 + COOL + 2);
    check("t1_reason", 32'(rst_reason), 32'b001);
    check("t1_idle", 32'(rst_busy), 32'd0);
    core_rdy = 1'b0;
    clear_flags();
    check("t1_cleared", 32'(rst_reason), 32'd0);

    // 2: wdt and sw rise in the same cycle.
    wdt_rst_req = 1'b1; sw_rst_req = 1'b1; tick();
    wdt_rst_req = 1'b0; sw_rst_req = 1'b0;
    ticks(2 + HOLD + 3);
    core_rdy = 1'b1; ticks(3 + COOL + 2);
    check("t2_reason", 32'(rst_reason), 32'b110);
    check("t2_no_tmo", 32'(timeout_flag), 32'd0);
    core_rdy = 1'b0;
    clear_flags();

    // 3: sw pulse with core_rdy held low -> timeout.
    sw_rst_req = 1'b1; tick();
    sw_rst_req = 1'b0;
    ticks(2 + HOLD + TMO + COOL + 2);
    check("t3_tmo", 32'(timeout_flag), 32'd1);
    check("t3_idle", 32'(rst_busy), 32'd0);
    clear_flags();
    check("t3_clr_tmo", 32'(timeout_flag), 32'd0);
    check("t3_clr_rsn", 32'(rst_reason), 32'd0);

    // 4: wdt in WAIT at cycle 5, then a request during COOL.
    wdt_rst_req = 1'b1; tick();
    wdt_rst_req = 1'b0;
    ticks(1 + HOLD + 3);
    wdt_rst_req = 1'b1; tick();
    wdt_rst_req = 1'b0;
    ticks(2 + HOLD - 1);
    check("t4_rehold", 32'(core_rstn_out), 32'd0);
    ticks(3);
    core_rdy = 1'b1; ticks(4);
    sw_rst_req = 1'b1; tick();
    sw_rst_req = 1'b0;
    ticks(COOL + 4);
    check("t4_no_reassert", 32'(core_rstn_out), 32'd1);
    core_rdy = 1'b0;
    clear_flags();

    // 5: asynchronous reset at HOLD cycle 10.
    wdt_rst_req = 1'b1; tick();
    wdt_rst_req = 1'b0;
    ticks(2 + 10);
    por_dbg_mix_rstn = 1'b0; model_reset();
    tick();
    check("t5_rst_reason", 32'(rst_reason), 32'd0);
    por_dbg_mix_rstn = 1'b1;
    tick();
    check("t5_idle", 32'(rst_busy), 32'd0);

`ifdef AOPD_RSTREQ_DEBOUNCE_EN
    // 6: 7-clk glitch is ignored; 9-clk low asserts 8+3 clk after pad edge.
    ext_rstn_pad = 1'b0; ticks(7);
    ext_rstn_pad = 1'b1; ticks(12);
    check("t6_glitch", 32'(rst_busy), 32'd0);
    ext_rstn_pad = 1'b0; ticks(DBNC + 2);
    check("t6_pre", 32'(core_rstn_out), 32'd1);
    tick();
    check("t6_assert", 32'(core_rstn_out), 32'd0);
    ext_rstn_pad = 1'b1;
    core_rdy = 1'b1; ticks(HOLD + COOL + 8);
    core_rdy = 1'b0;
    clear_flags();
`endif

    // Random traffic: short request pulses, wandering core_rdy / reason_clr,
    // occasional asynchronous reset.
    pad_t = 0; wdt_t = 0; sw_t = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (pad_t > 0) pad_t--; else if ($urandom_range(0, 59) == 0) pad_t = $urandom_range(1, 14);
      if (wdt_t > 0) wdt_t--; else if ($urandom_range(0, 79) == 0) wdt_t = $urandom_range(1, 6);
      if (sw_t > 0)  sw_t--;  else if ($urandom_range(0, 79) == 0) sw_t  = $urandom_range(1, 6);
      ext_rstn_pad = (pad_t == 0);
      wdt_rst_req  = (wdt_t != 0);
      sw_rst_req   = (sw_t != 0);
      if ($urandom_range(0, 29) == 0) core_rdy   = ~core_rdy;
      if ($urandom_range(0, 39) == 0) reason_clr = ~reason_clr;
      if (!por_dbg_mix_rstn) por_dbg_mix_rstn = 1'b1;
      else if ($urandom_range(0, 1499) == 0) begin
        por_dbg_mix_rstn = 1'b0;
        model_reset();
      end
    end
    por_dbg_mix_rstn = 1'b1;
    ticks(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ae350_aopd_rstreq_seq
